// File: rtl/pipeline_id_stage_if.sv
// Fetch/decode boundary bundle: fetch inputs, EX/MEM/WB hazard taps, fetch control and ID/EX outputs.
interface pipeline_id_stage_if;
   logic [31:0] if_pc;
   logic [31:0] if_next_pc;
   logic [31:0] if_instruction;
   logic [4:0]  ex_write_reg;
   logic        ex_reg_write;
   logic        ex_mem_read;
   logic [4:0]  mem_write_reg;
   logic        mem_reg_write;
   logic        mem_mem_read;
   logic [31:0] mem_result;
   logic [4:0]  wb_write_reg;
   logic        wb_reg_write;
   logic [31:0] wb_data;
   logic        pause;
   logic [1:0]  pc_select;
   logic [31:0] branch_address;
   logic [31:0] jump_address;
   logic        id_valid;
   logic [31:0] id_pc;
   logic [31:0] id_next_pc;
   logic [31:0] id_instruction;
   logic [31:0] id_rs_data;
   logic [31:0] id_rt_data;
   logic [31:0] id_imm;
   logic [4:0]  id_write_reg;
   logic        id_reg_write;
   logic        id_mem_read;
   logic        id_mem_write;

   modport slave (
      input  if_pc, if_next_pc, if_instruction,
             ex_write_reg, ex_reg_write, ex_mem_read,
             mem_write_reg, mem_reg_write, mem_mem_read, mem_result,
             wb_write_reg, wb_reg_write, wb_data,
      output pause, pc_select, branch_address, jump_address,
             id_valid, id_pc, id_next_pc, id_instruction,
             id_rs_data, id_rt_data, id_imm, id_write_reg,
             id_reg_write, id_mem_read, id_mem_write
   );

   modport master (
      output if_pc, if_next_pc, if_instruction,
             ex_write_reg, ex_reg_write, ex_mem_read,
             mem_write_reg, mem_reg_write, mem_mem_read, mem_result,
             wb_write_reg, wb_reg_write, wb_data,
      input  pause, pc_select, branch_address, jump_address,
             id_valid, id_pc, id_next_pc, id_instruction,
             id_rs_data, id_rt_data, id_imm, id_write_reg,
             id_reg_write, id_mem_read, id_mem_write
   );
endinterface

// File: rtl/pipeline_id_stage.sv
// Decode stage: IF/ID latch, 32x32 regfile, decode, branch/jump resolution, ID/EX register.
// Two-edge latency IF->ID/EX; pause holds IF/ID and injects a bubble into ID/EX.
module pipeline_id_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input logic                 clock,
   input logic                 reset,
   pipeline_id_stage_if.slave  bus
);
   localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03,
                          OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDIU = 6'h09,
                          OP_SLTI  = 6'h0A, OP_ANDI = 6'h0C, OP_ORI  = 6'h0D,
                          OP_XORI  = 6'h0E, OP_LUI  = 6'h0F, OP_LW   = 6'h23,
                          OP_SW    = 6'h2B;
   localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_JR  = 6'h08,
                          FN_ADDU = 6'h21, FN_SUBU = 6'h23, FN_AND = 6'h24,
                          FN_OR  = 6'h25, FN_XOR = 6'h26, FN_SLT = 6'h2A;

   logic        r_ifid_valid;
   logic [31:0] r_ifid_pc, r_ifid_next_pc, r_ifid_instr;
   logic [31:0] r_regs [32];

   logic        r_id_valid, r_id_reg_write, r_id_mem_read, r_id_mem_write;
   logic [31:0] r_id_pc, r_id_next_pc, r_id_instruction;
   logic [31:0] r_id_rs_data, r_id_rt_data, r_id_imm;
   logic [4:0]  r_id_write_reg;

   logic [5:0]  w_op, w_funct;
   logic [4:0]  w_rs, w_rt, w_rd;
   logic [31:0] w_imm_sext;
   assign w_op       = r_ifid_instr[31:26];
   assign w_funct    = r_ifid_instr[5:0];
   assign w_rs       = r_ifid_instr[25:21];
   assign w_rt       = r_ifid_instr[20:16];
   assign w_rd       = r_ifid_instr[15:11];
   assign w_imm_sext = {{16{r_ifid_instr[15]}}, r_ifid_instr[15:0]};

   logic        w_reads_rs, w_reads_rt, w_has_dest, w_mem_read, w_mem_write;
   logic        w_is_beq, w_is_bne, w_is_j, w_is_jr, w_reg_write;
   logic [4:0]  w_dest;
   logic [31:0] w_imm;

   always_comb begin
      w_reads_rs  = 1'b0;
      w_reads_rt  = 1'b0;
      w_has_dest  = 1'b0;
      w_dest      = 5'd0;
      w_imm       = 32'd0;
      w_mem_read  = 1'b0;
      w_mem_write = 1'b0;
      w_is_beq    = 1'b0;
      w_is_bne    = 1'b0;
      w_is_j      = 1'b0;
      w_is_jr     = 1'b0;
      case (w_op)
         OP_RTYPE: begin
            case (w_funct)
               FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_SLT: begin
                  w_reads_rs = 1'b1;
                  w_reads_rt = 1'b1;
                  w_has_dest = 1'b1;
                  w_dest     = w_rd;
               end
               FN_SLL, FN_SRL: begin
                  w_reads_rt = 1'b1;
                  w_has_dest = 1'b1;
                  w_dest     = w_rd;
               end
               FN_JR: begin
                  w_reads_rs = 1'b1;
                  w_is_jr    = 1'b1;
               end
               default: ;
            endcase
         end
         OP_ADDIU, OP_SLTI, OP_LW: begin
            w_reads_rs = 1'b1;
            w_has_dest = 1'b1;
            w_dest     = w_rt;
            w_imm      = w_imm_sext;
            w_mem_read = (w_op == OP_LW);
         end
         OP_ANDI, OP_ORI, OP_XORI: begin
            w_reads_rs = 1'b1;
            w_has_dest = 1'b1;
            w_dest     = w_rt;
            w_imm      = {16'd0, r_ifid_instr[15:0]};
         end
         OP_LUI: begin
            w_has_dest = 1'b1;
            w_dest     = w_rt;
            w_imm      = {r_ifid_instr[15:0], 16'd0};
         end
         OP_SW: begin
            w_reads_rs  = 1'b1;
            w_reads_rt  = 1'b1;
            w_imm       = w_imm_sext;
            w_mem_write = 1'b1;
         end
         OP_BEQ, OP_BNE: begin
            w_reads_rs = 1'b1;
            w_reads_rt = 1'b1;
            w_imm      = w_imm_sext;
            w_is_beq   = (w_op == OP_BEQ);
            w_is_bne   = (w_op == OP_BNE);
         end
         OP_J: w_is_j = 1'b1;
         OP_JAL: begin
            w_is_j     = 1'b1;
            w_has_dest = 1'b1;
            w_dest     = 5'd31;
         end
         default: ;
      endcase
   end

   assign w_reg_write = w_has_dest && (w_dest != 5'd0);

   // Regfile read with write-first bypass, then MEM forwarding for branch/jr operands only.
   logic [31:0] w_rs_rf, w_rt_rf, w_rs_fwd, w_rt_fwd;
   assign w_rs_rf  = (w_rs == 5'd0) ? 32'd0 :
                     (bus.wb_reg_write && bus.wb_write_reg == w_rs) ? bus.wb_data : r_regs[w_rs];
   assign w_rt_rf  = (w_rt == 5'd0) ? 32'd0 :
                     (bus.wb_reg_write && bus.wb_write_reg == w_rt) ? bus.wb_data : r_regs[w_rt];
   assign w_rs_fwd = (w_rs != 5'd0 && bus.mem_reg_write && !bus.mem_mem_read &&
                      bus.mem_write_reg == w_rs) ? bus.mem_result : w_rs_rf;
   assign w_rt_fwd = (w_rt != 5'd0 && bus.mem_reg_write && !bus.mem_mem_read &&
                      bus.mem_write_reg == w_rt) ? bus.mem_result : w_rt_rf;

   logic w_load_use, w_rs_busy, w_rt_busy, w_ctrl_hazard, w_pause;
   assign w_load_use = r_ifid_valid && bus.ex_mem_read && bus.ex_write_reg != 5'd0 &&
                       ((w_reads_rs && bus.ex_write_reg == w_rs) ||
                        (w_reads_rt && bus.ex_write_reg == w_rt));
   assign w_rs_busy  = w_rs != 5'd0 &&
                       ((bus.ex_reg_write && bus.ex_write_reg == w_rs) ||
                        (bus.mem_mem_read && bus.mem_write_reg == w_rs));
   assign w_rt_busy  = w_rt != 5'd0 &&
                       ((bus.ex_reg_write && bus.ex_write_reg == w_rt) ||
                        (bus.mem_mem_read && bus.mem_write_reg == w_rt));
   assign w_ctrl_hazard = r_ifid_valid && (w_is_beq || w_is_bne || w_is_jr) &&
                          ((w_reads_rs && w_rs_busy) || (w_reads_rt && w_rt_busy));
   assign w_pause = w_load_use || w_ctrl_hazard;

   logic w_equal, w_redirect_br, w_redirect_jmp, w_redirect;
   assign w_equal        = (w_rs_fwd == w_rt_fwd);
   assign w_redirect_br  = r_ifid_valid && !w_pause &&
                           ((w_is_beq && w_equal) || (w_is_bne && !w_equal));
   assign w_redirect_jmp = r_ifid_valid && !w_pause && (w_is_j || w_is_jr);
   assign w_redirect     = w_redirect_br || w_redirect_jmp;

   assign bus.pause          = w_pause;
   assign bus.pc_select      = w_redirect_jmp ? 2'b10 : (w_redirect_br ? 2'b01 : 2'b00);
   assign bus.branch_address = r_ifid_valid ? r_ifid_next_pc + {w_imm_sext[29:0], 2'b00} : 32'd0;
   assign bus.jump_address   = !r_ifid_valid ? 32'd0 :
                               w_is_jr ? w_rs_fwd :
                               {r_ifid_next_pc[31:28], r_ifid_instr[25:0], 2'b00};

   always_ff @(posedge clock) begin
      if (reset || (!w_pause && w_redirect)) begin
         r_ifid_valid   <= 1'b0;
         r_ifid_pc      <= RESET_PC;
         r_ifid_next_pc <= RESET_PC;
         r_ifid_instr   <= 32'd0;
      end else if (!w_pause) begin
         r_ifid_valid   <= 1'b1;
         r_ifid_pc      <= bus.if_pc;
         r_ifid_next_pc <= bus.if_next_pc;
         r_ifid_instr   <= bus.if_instruction;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) r_regs[i] <= 32'd0;
      end else if (bus.wb_reg_write && bus.wb_write_reg != 5'd0) begin
         r_regs[bus.wb_write_reg] <= bus.wb_data;
      end
   end

   always_ff @(posedge clock) begin
      if (reset || w_pause || !r_ifid_valid) begin
         r_id_valid       <= 1'b0;
         r_id_pc          <= RESET_PC;
         r_id_next_pc     <= RESET_PC;
         r_id_instruction <= 32'd0;
         r_id_rs_data     <= 32'd0;
         r_id_rt_data     <= 32'd0;
         r_id_imm         <= 32'd0;
         r_id_write_reg   <= 5'd0;
         r_id_reg_write   <= 1'b0;
         r_id_mem_read    <= 1'b0;
         r_id_mem_write   <= 1'b0;
      end else begin
         r_id_valid       <= 1'b1;
         r_id_pc          <= r_ifid_pc;
         r_id_next_pc     <= r_ifid_next_pc;
         r_id_instruction <= r_ifid_instr;
         r_id_rs_data     <= w_rs_rf;
         r_id_rt_data     <= w_rt_rf;
         r_id_imm         <= w_imm;
         r_id_write_reg   <= w_dest;
         r_id_reg_write   <= w_reg_write;
         r_id_mem_read    <= w_mem_read;
         r_id_mem_write   <= w_mem_write;
      end
   end

   assign bus.id_valid       = r_id_valid;
   assign bus.id_pc          = r_id_pc;
   assign bus.id_next_pc     = r_id_next_pc;
   assign bus.id_instruction = r_id_instruction;
   assign bus.id_rs_data     = r_id_rs_data;
   assign bus.id_rt_data     = r_id_rt_data;
   assign bus.id_imm         = r_id_imm;
   assign bus.id_write_reg   = r_id_write_reg;
   assign bus.id_reg_write   = r_id_reg_write;
   assign bus.id_mem_read    = r_id_mem_read;
   assign bus.id_mem_write   = r_id_mem_write;
endmodule

// File: tb/tb_pipeline_id_stage.sv
// Bench for pipeline_id_stage: mnemonic-level reference model checked every cycle, plus literal expectations.
module tb_pipeline_id_stage;
   logic clock = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_errors = 0;
   bit   cmp_en   = 1'b0;

   pipeline_id_stage_if ifc ();
   pipeline_id_stage #(.RESET_PC(32'h0)) dut (.clock(clock), .reset(reset), .bus(ifc));

   always #5 clock = ~clock;

   localparam int K_NONE = 0, K_BEQ = 1, K_BNE = 2, K_J = 3, K_JAL = 4, K_JR = 5;

   typedef struct {
      bit          rs_used;
      bit          rt_used;
      logic [4:0]  dst;
      bit          wr;
      bit          ld;
      bit          st;
      logic [31:0] imm;
      int          kind;
   } dec_t;

   function automatic string mnem(input logic [31:0] w);
      string n = "nop";
      if (w[31:26] == 6'h00) begin
         case (w[5:0])
            6'h21: n = "addu";  6'h23: n = "subu";  6'h24: n = "and";
            6'h25: n = "or";    6'h26: n = "xor";   6'h2A: n = "slt";
            6'h00: n = "sll";   6'h02: n = "srl";   6'h08: n = "jr";
            default: n = "nop";
         endcase
      end else begin
         case (w[31:26])
            6'h09: n = "addiu"; 6'h0C: n = "andi";  6'h0D: n = "ori";
            6'h0E: n = "xori";  6'h0F: n = "lui";   6'h0A: n = "slti";
            6'h23: n = "lw";    6'h2B: n = "sw";    6'h04: n = "beq";
            6'h05: n = "bne";   6'h02: n = "j";     6'h03: n = "jal";
            default: n = "nop";
         endcase
      end
      return n;
   endfunction

   function automatic dec_t decode(input logic [31:0] w);
      dec_t  d;
      string n = mnem(w);
      logic [31:0] s16 = 32'(int'($signed(w[15:0])));
      d.rs_used = 0; d.rt_used = 0; d.dst = 5'd0; d.wr = 0;
      d.ld = 0; d.st = 0; d.imm = 32'd0; d.kind = K_NONE;
      case (n)
         "addu", "subu", "and", "or", "xor", "slt": begin
            d.rs_used = 1; d.rt_used = 1; d.dst = w[15:11]; d.wr = 1;
         end
         "sll", "srl": begin d.rt_used = 1; d.dst = w[15:11]; d.wr = 1; end
         "jr":   begin d.rs_used = 1; d.kind = K_JR; end
         "addiu", "slti": begin d.rs_used = 1; d.dst = w[20:16]; d.wr = 1; d.imm = s16; end
         "andi", "ori", "xori": begin
            d.rs_used = 1; d.dst = w[20:16]; d.wr = 1; d.imm = 32'(w[15:0]);
         end
         "lui":  begin d.dst = w[20:16]; d.wr = 1; d.imm = 32'(w[15:0]) * 32'd65536; end
         "lw":   begin d.rs_used = 1; d.dst = w[20:16]; d.wr = 1; d.ld = 1; d.imm = s16; end
         "sw":   begin d.rs_used = 1; d.rt_used = 1; d.st = 1; d.imm = s16; end
         "beq":  begin d.rs_used = 1; d.rt_used = 1; d.imm = s16; d.kind = K_BEQ; end
         "bne":  begin d.rs_used = 1; d.rt_used = 1; d.imm = s16; d.kind = K_BNE; end
         "j":    d.kind = K_J;
         "jal":  begin d.kind = K_JAL; d.dst = 5'd31; d.wr = 1; end
         default: ;
      endcase
      if (d.dst == 5'd0) d.wr = 0;
      return d;
   endfunction

   // Reference state: IF/ID contents, architectural registers and expected ID/EX contents.
   logic        m_fv;
   logic [31:0] m_fpc, m_fnpc, m_finstr;
   logic [31:0] m_rf [32];
   logic        m_v, m_wr, m_ld, m_st;
   logic [31:0] m_pc, m_npc, m_instr, m_rsd, m_rtd, m_imm;
   logic [4:0]  m_wreg;

   function automatic logic [31:0] rf_read(input logic [4:0] r);
      if (r == 5'd0) return 32'd0;
      if (ifc.wb_reg_write && ifc.wb_write_reg == r) return ifc.wb_data;
      return m_rf[r];
   endfunction

   function automatic logic [31:0] newest(input logic [4:0] r);
      if (r != 5'd0 && ifc.mem_reg_write && !ifc.mem_mem_read && ifc.mem_write_reg == r)
         return ifc.mem_result;
      return rf_read(r);
   endfunction

   function automatic bit src_stalls(input logic [4:0] r, input int kind);
      bit s = 0;
      if (r == 5'd0) return 0;
      if (ifc.ex_mem_read && ifc.ex_write_reg == r) s = 1;
      if ((kind == K_BEQ || kind == K_BNE || kind == K_JR) &&
          ((ifc.ex_reg_write && ifc.ex_write_reg == r) ||
           (ifc.mem_mem_read && ifc.mem_write_reg == r))) s = 1;
      return s;
   endfunction

   task automatic expect_now(output logic p, output logic [1:0] ps,
                             output logic [31:0] ba, output logic [31:0] ja,
                             output logic [31:0] rsd, output logic [31:0] rtd,
                             output dec_t d);
      logic [4:0]  rs = m_finstr[25:21];
      logic [4:0]  rt = m_finstr[20:16];
      logic [31:0] a  = newest(rs);
      logic [31:0] b  = newest(rt);
      d   = decode(m_finstr);
      rsd = rf_read(rs);
      rtd = rf_read(rt);
      p   = m_fv && ((d.rs_used && src_stalls(rs, d.kind)) || (d.rt_used && src_stalls(rt, d.kind)));
      ps  = 2'b00;
      if (m_fv && !p) begin
         if (d.kind == K_J || d.kind == K_JAL || d.kind == K_JR) ps = 2'b10;
         else if ((d.kind == K_BEQ && a == b) || (d.kind == K_BNE && a != b)) ps = 2'b01;
      end
      ba = m_fv ? m_fnpc + 32'(int'($signed(m_finstr[15:0])) * 4) : 32'd0;
      ja = !m_fv ? 32'd0 : (d.kind == K_JR) ? a : {m_fnpc[31:28], m_finstr[25:0], 2'b00};
   endtask

   task automatic m_bubble();
      m_v = 0; m_pc = 0; m_npc = 0; m_instr = 0; m_rsd = 0; m_rtd = 0;
      m_imm = 0; m_wreg = 0; m_wr = 0; m_ld = 0; m_st = 0;
   endtask

   always @(posedge clock) begin
      logic p; logic [1:0] ps; logic [31:0] ba, ja, rsd, rtd; dec_t d;
      if (reset) begin
         m_fv = 0; m_fpc = 0; m_fnpc = 0; m_finstr = 0;
         for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
         m_bubble();
      end else begin
         expect_now(p, ps, ba, ja, rsd, rtd, d);
         if (p || !m_fv) m_bubble();
         else begin
            m_v = 1; m_pc = m_fpc; m_npc = m_fnpc; m_instr = m_finstr; m_rsd = rsd;
            m_rtd = rtd; m_imm = d.imm; m_wreg = d.dst; m_wr = d.wr; m_ld = d.ld; m_st = d.st;
         end
         if (!p) begin
            if (ps != 2'b00) begin
               m_fv = 0; m_fpc = 0; m_fnpc = 0; m_finstr = 0;
            end else begin
               m_fv = 1; m_fpc = ifc.if_pc; m_fnpc = ifc.if_next_pc; m_finstr = ifc.if_instruction;
            end
         end
         if (ifc.wb_reg_write && ifc.wb_write_reg != 5'd0) m_rf[ifc.wb_write_reg] = ifc.wb_data;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clock) begin
      logic p; logic [1:0] ps; logic [31:0] ba, ja, rsd, rtd; dec_t d;
      if (cmp_en) begin
         expect_now(p, ps, ba, ja, rsd, rtd, d);
         chk("pause", 32'(ifc.pause), 32'(p));
         chk("pc_select", 32'(ifc.pc_select), 32'(ps));
         chk("branch_address", ifc.branch_address, ba);
         chk("jump_address", ifc.jump_address, ja);
         chk("id_valid", 32'(ifc.id_valid), 32'(m_v));
         chk("id_pc", ifc.id_pc, m_pc);
         chk("id_next_pc", ifc.id_next_pc, m_npc);
         chk("id_instruction", ifc.id_instruction, m_instr);
         chk("id_rs_data", ifc.id_rs_data, m_rsd);
         chk("id_rt_data", ifc.id_rt_data, m_rtd);
         chk("id_imm", ifc.id_imm, m_imm);
         chk("id_write_reg", 32'(ifc.id_write_reg), 32'(m_wreg));
         chk("id_reg_write", 32'(ifc.id_reg_write), 32'(m_wr));
         chk("id_mem_read", 32'(ifc.id_mem_read), 32'(m_ld));
         chk("id_mem_write", 32'(ifc.id_mem_write), 32'(m_st));
      end
   end

   task automatic fetch(input logic [31:0] pc, input logic [31:0] ins);
      ifc.if_pc = pc; ifc.if_next_pc = pc + 32'd4; ifc.if_instruction = ins;
   endtask

   task automatic side_clear();
      ifc.ex_write_reg = 0; ifc.ex_reg_write = 0; ifc.ex_mem_read = 0;
      ifc.mem_write_reg = 0; ifc.mem_reg_write = 0; ifc.mem_mem_read = 0; ifc.mem_result = 0;
      ifc.wb_write_reg = 0; ifc.wb_reg_write = 0; ifc.wb_data = 0;
   endtask

   task automatic wb(input logic [4:0] r, input logic [31:0] v);
      ifc.wb_reg_write = 1; ifc.wb_write_reg = r; ifc.wb_data = v;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   localparam logic [31:0] I_ADDIU1 = 32'h2401_0005, I_ADDU4 = 32'h0060_2021,
                           I_ADDU5  = 32'h0042_2821, I_BEQ   = 32'h1021_0003,
                           I_BNE    = 32'h14C0_FFFF, I_JAL   = 32'h0C00_0040,
                           I_JR31   = 32'h03E0_0008;

   logic [31:0] tbl [21] = '{
      32'h0022_3823, 32'h0064_4024, 32'h0020_4825, 32'h0043_5026, 32'h0022_582A,
      32'h0002_6100, 32'h0003_6842, 32'h302E_8000, 32'h340F_FFFF, 32'h3850_1234,
      32'h3C11_ABCD, 32'h2832_FFFE, 32'hACA4_0008, 32'h8C20_0000, 32'h0022_0021,
      32'hFC22_1234, 32'h0022_183F, 32'h1422_0002, 32'h1000_FFFC, 32'h0800_0123,
      32'h03E0_0008};

   initial begin
      reset = 1'b1; side_clear(); fetch(32'h0, 32'h0);
      tick(); cmp_en = 1'b1;
      tick();
      @(negedge clock);
      chk("reset id_valid", 32'(ifc.id_valid), 32'd0);
      chk("reset id_pc", ifc.id_pc, 32'h0);
      chk("reset pause", 32'(ifc.pause), 32'd0);
      chk("reset pc_select", 32'(ifc.pc_select), 32'd0);
      tick();
      reset = 1'b0; fetch(32'h0, I_ADDIU1);
      @(negedge clock); chk("s1 pause", 32'(ifc.pause), 32'd0);
      tick(); fetch(32'h4, 32'h0);
      @(negedge clock);
      chk("addiu pause", 32'(ifc.pause), 32'd0);
      chk("addiu pc_select", 32'(ifc.pc_select), 32'd0);
      tick(); fetch(32'h8, I_ADDU4);
      @(negedge clock);
      chk("addiu id_valid", 32'(ifc.id_valid), 32'd1);
      chk("addiu id_imm", ifc.id_imm, 32'd5);
      chk("addiu id_write_reg", 32'(ifc.id_write_reg), 32'd1);
      chk("addiu id_reg_write", 32'(ifc.id_reg_write), 32'd1);
      tick(); fetch(32'hC, 32'h0); wb(5'd3, 32'hDEAD_BEEF);
      tick(); fetch(32'h10, 32'h0); wb(5'd1, 32'd7);
      @(negedge clock); chk("bypass id_rs_data", ifc.id_rs_data, 32'hDEAD_BEEF);
      tick(); fetch(32'h14, I_ADDU5); wb(5'd6, 32'd9);
      tick(); side_clear(); fetch(32'h18, 32'h0);
      ifc.ex_mem_read = 1; ifc.ex_reg_write = 1; ifc.ex_write_reg = 5'd2;
      @(negedge clock); chk("loaduse pause", 32'(ifc.pause), 32'd1);
      tick(); side_clear();
      @(negedge clock);
      chk("loaduse bubble id_valid", 32'(ifc.id_valid), 32'd0);
      chk("loaduse released pause", 32'(ifc.pause), 32'd0);
      tick(); fetch(32'h10, I_BEQ);
      @(negedge clock);
      chk("addu5 id_valid", 32'(ifc.id_valid), 32'd1);
      chk("addu5 id_write_reg", 32'(ifc.id_write_reg), 32'd5);
      tick(); fetch(32'h14, I_ADDIU1);
      @(negedge clock);
      chk("beq pc_select", 32'(ifc.pc_select), 32'd1);
      chk("beq branch_address", ifc.branch_address, 32'h20);
      tick(); fetch(32'h20, I_BNE);
      @(negedge clock);
      chk("beq id_valid", 32'(ifc.id_valid), 32'd1);
      chk("beq id_pc", ifc.id_pc, 32'h10);
      chk("after beq pc_select", 32'(ifc.pc_select), 32'd0);
      tick(); fetch(32'h24, 32'h0);
      ifc.mem_write_reg = 5'd6; ifc.mem_reg_write = 1; ifc.mem_result = 32'd0;
      @(negedge clock);
      chk("wrong path id_valid", 32'(ifc.id_valid), 32'd0);
      chk("bne fwd pc_select", 32'(ifc.pc_select), 32'd0);
      tick(); side_clear(); fetch(32'h100, I_JAL);
      tick(); fetch(32'h104, 32'h0);
      @(negedge clock);
      chk("jal pc_select", 32'(ifc.pc_select), 32'd2);
      chk("jal jump_address", ifc.jump_address, 32'h100);
      tick(); fetch(32'h200, I_JR31);
      @(negedge clock);
      chk("jal id_write_reg", 32'(ifc.id_write_reg), 32'd31);
      chk("jal id_next_pc", ifc.id_next_pc, 32'h104);
      chk("jal id_reg_write", 32'(ifc.id_reg_write), 32'd1);
      tick(); fetch(32'h204, 32'h0); ifc.ex_write_reg = 5'd31; ifc.ex_reg_write = 1;
      @(negedge clock);
      chk("jr ex pause", 32'(ifc.pause), 32'd1);
      chk("jr ex pc_select", 32'(ifc.pc_select), 32'd0);
      tick(); side_clear();
      ifc.mem_write_reg = 5'd31; ifc.mem_reg_write = 1; ifc.mem_result = 32'h200;
      @(negedge clock);
      chk("jr mem pause", 32'(ifc.pause), 32'd0);
      chk("jr pc_select", 32'(ifc.pc_select), 32'd2);
      chk("jr jump_address", ifc.jump_address, 32'h200);
      tick(); side_clear(); fetch(32'h300, I_ADDU5);
      tick(); fetch(32'h304, 32'h0);
      ifc.ex_mem_read = 1; ifc.ex_write_reg = 5'd2; reset = 1'b1;
      @(negedge clock); chk("stall before reset pause", 32'(ifc.pause), 32'd1);
      tick(); side_clear(); reset = 1'b0;
      @(negedge clock);
      chk("reset in stall id_valid", 32'(ifc.id_valid), 32'd0);
      chk("reset in stall pause", 32'(ifc.pause), 32'd0);
      chk("reset in stall pc_select", 32'(ifc.pc_select), 32'd0);
      chk("reset in stall id_rs_data", ifc.id_rs_data, 32'd0);
      for (int i = 0; i < 21; i++) begin
         tick(); side_clear(); fetch(32'h400 + 32'(4 * i), tbl[i]);
         wb(5'(i), 32'h1111_0000 + 32'(i));
         if (i % 5 == 3) begin
            ifc.ex_mem_read = 1; ifc.ex_reg_write = 1; ifc.ex_write_reg = 5'(i % 4 + 1);
         end
         if (i % 6 == 1) begin
            ifc.mem_reg_write = 1; ifc.mem_write_reg = 5'd1; ifc.mem_result = 32'h2222_0000 + 32'(i);
         end
         if (i % 7 == 4) begin
            ifc.mem_reg_write = 1; ifc.mem_mem_read = 1; ifc.mem_write_reg = 5'd2;
         end
      end
      for (int i = 0; i < 4; i++) begin
         tick(); side_clear(); fetch(32'h500 + 32'(4 * i), 32'h0);
      end
      @(negedge clock);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
